// File: rtl/spi_multi_adapter.sv
// spi_multi_adapter
//   Bridges an SPI minion push/pull interface to num_channels independent
//   val/rdy stream channels. Every channel owns a master-to-chip (mc) queue
//   drained on send_* and a chip-to-master (cm) queue filled from recv_*.
//   SPI packets carry {chan, payload} in push_msg_data / pull_msg_data.
//   err_ovf (dropped write) and err_addr (bad channel ID) are sticky until reset.
//
//   Optional macro SPI_MULTI_ADAPTER_RR_EN: reads ignore the channel field and
//   are served round-robin from the first non-empty cm queue at/after rr_ptr.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   push_en, push_msg_val_wrt  write strobe / write flag
//   push_msg_val_rd            read flag
//   push_msg_data              {chan, payload} of the transaction
//   pull_en                    read strobe
//   pull_msg_val/spc/data      read valid, mc space flag, read response
//   recv_msg/val/rdy           per-channel chip-to-master streams
//   send_msg/val/rdy           per-channel master-to-chip streams
//   err_ovf, err_addr          sticky error flags
module spi_multi_adapter #(
    parameter int nbits        = 16,
    parameter int num_channels = 4,
    parameter int num_entries  = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        push_en,
    input  logic                                        push_msg_val_wrt,
    input  logic                                        push_msg_val_rd,
    input  logic [nbits-3:0]                            push_msg_data,
    input  logic                                        pull_en,
    output logic                                        pull_msg_val,
    output logic                                        pull_msg_spc,
    output logic [nbits-3:0]                            pull_msg_data,
    input  logic [num_channels*(nbits-2-$clog2(num_channels))-1:0] recv_msg,
    input  logic [num_channels-1:0]                     recv_val,
    output logic [num_channels-1:0]                     recv_rdy,
    output logic [num_channels*(nbits-2-$clog2(num_channels))-1:0] send_msg,
    output logic [num_channels-1:0]                     send_val,
    input  logic [num_channels-1:0]                     send_rdy,
    output logic                                        err_ovf,
    output logic                                        err_addr
);
    localparam int CW = $clog2(num_channels);
    localparam int PW = nbits - 2 - CW;
    localparam int NQ = 2 * num_channels;
    localparam int AW = (num_entries > 1) ? $clog2(num_entries) : 1;
    localparam int NW = $clog2(num_entries + 1);

    // Queues 0..num_channels-1 are mc, num_channels..NQ-1 are cm.
    logic [NQ-1:0] q_enq_val, q_enq_rdy, q_deq_val, q_deq_rdy;
    logic [PW-1:0] q_enq_msg [NQ];
    logic [PW-1:0] q_deq_msg [NQ];
    logic [AW-1:0] q_head [NQ];
    logic [AW-1:0] q_tail [NQ];
    logic [NW-1:0] q_cnt  [NQ];
    logic [PW-1:0] q_mem  [NQ][num_entries];

    logic                    wr, rd, ch_ok, found;
    logic [CW-1:0]           ch, ch_idx, target;
    logic [num_channels-1:0] mc_rdy, mc_room2, cm_val;
    logic [PW-1:0]           cm_msg [num_channels];

    assign wr     = push_en & push_msg_val_wrt;
    assign rd     = pull_en & push_msg_val_rd;
    assign ch     = push_msg_data[nbits-3 -: CW];
    assign ch_ok  = int'(ch) < num_channels;
    // Out-of-range IDs are folded to 0 only to keep array reads in bounds;
    // every use is also qualified by ch_ok.
    assign ch_idx = ch_ok ? ch : '0;

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        assign q_enq_rdy[q] = ~reset & (q_cnt[q] < NW'(num_entries));
        assign q_deq_val[q] = q_cnt[q] != '0;
        assign q_deq_msg[q] = q_mem[q][q_head[q]];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q_head[q] <= '0;
                q_tail[q] <= '0;
                q_cnt[q]  <= '0;
            end else begin
                if (q_enq_val[q] & q_enq_rdy[q])
                    q_tail[q] <= (q_tail[q] == AW'(num_entries-1)) ? '0 : q_tail[q] + AW'(1);
                if (q_deq_rdy[q] & q_deq_val[q])
                    q_head[q] <= (q_head[q] == AW'(num_entries-1)) ? '0 : q_head[q] + AW'(1);
                if ((q_enq_val[q] & q_enq_rdy[q]) & ~(q_deq_rdy[q] & q_deq_val[q]))
                    q_cnt[q] <= q_cnt[q] + NW'(1);
                else if (~(q_enq_val[q] & q_enq_rdy[q]) & (q_deq_rdy[q] & q_deq_val[q]))
                    q_cnt[q] <= q_cnt[q] - NW'(1);
            end
        end

        // Storage carries no reset; occupancy is tracked by q_cnt alone.
        always_ff @(posedge clk) begin
            if (q_enq_val[q] & q_enq_rdy[q])
                q_mem[q][q_tail[q]] <= q_enq_msg[q];
        end
    end

    for (genvar g = 0; g < num_channels; g++) begin : g_chan
        assign q_enq_val[g]             = wr & ch_ok & (ch_idx == CW'(g));
        assign q_enq_msg[g]             = push_msg_data[PW-1:0];
        assign q_deq_rdy[g]             = send_rdy[g];
        assign send_val[g]              = q_deq_val[g];
        assign send_msg[g*PW +: PW]     = q_deq_msg[g];
        assign mc_rdy[g]                = q_enq_rdy[g];
        // More than one free slot: a write in flight still leaves room.
        assign mc_room2[g]              = q_cnt[g] < NW'(num_entries-1);

        assign q_enq_val[num_channels+g] = recv_val[g];
        assign q_enq_msg[num_channels+g] = recv_msg[g*PW +: PW];
        assign recv_rdy[g]               = q_enq_rdy[num_channels+g];
        assign q_deq_rdy[num_channels+g] = pull_msg_val & (target == CW'(g));
        assign cm_val[g]                 = q_deq_val[num_channels+g];
        assign cm_msg[g]                 = q_deq_msg[num_channels+g];
    end

    assign pull_msg_spc = ~reset & ch_ok & mc_rdy[ch_idx] & (~wr | mc_room2[ch_idx]);

`ifdef SPI_MULTI_ADAPTER_RR_EN
    logic [CW-1:0] rr_ptr;

    always_comb begin
        int idx;
        idx    = 0;
        target = '0;
        found  = 1'b0;
        for (int k = 0; k < num_channels; k++) begin
            idx = (int'(rr_ptr) + k) % num_channels;
            if (!found && cm_val[idx]) begin
                found  = 1'b1;
                target = CW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (pull_msg_val)
            rr_ptr <= (int'(target) == num_channels - 1) ? '0 : target + CW'(1);
    end
`else
    always_comb begin
        target = ch_idx;
        found  = ch_ok & cm_val[ch_idx];
    end
`endif

    assign pull_msg_val  = ~reset & rd & found;
    assign pull_msg_data = pull_msg_val ? {target, cm_msg[target]} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_ovf  <= 1'b0;
            err_addr <= 1'b0;
        end else begin
            if (wr & ch_ok & ~mc_rdy[ch_idx])
                err_ovf <= 1'b1;
`ifdef SPI_MULTI_ADAPTER_RR_EN
            if (wr & ~ch_ok)
                err_addr <= 1'b1;
`else
            if ((wr | rd) & ~ch_ok)
                err_addr <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_spi_multi_adapter.sv
module tb_spi_multi_adapter;
    localparam int PW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 4-channel DUT
    logic        push_en, wrt, rdf, pull_en;
    logic [13:0] push_data;
    logic        pull_val, pull_spc;
    logic [13:0] pull_data;
    logic [47:0] recv_msg, send_msg;
    logic [3:0]  recv_val, recv_rdy, send_val, send_rdy;
    logic        err_ovf, err_addr;

    // 3-channel DUT for out-of-range IDs
    logic        t_push_en, t_wrt, t_rdf, t_pull_en;
    logic [13:0] t_push_data;
    logic        t_pull_val, t_pull_spc;
    logic [13:0] t_pull_data;
    logic [35:0] t_recv_msg, t_send_msg;
    logic [2:0]  t_recv_val, t_recv_rdy, t_send_val, t_send_rdy;
    logic        t_err_ovf, t_err_addr;

    spi_multi_adapter #(.nbits(16), .num_channels(4), .num_entries(2)) dut (
        .clk(clk), .reset(reset), .push_en(push_en), .push_msg_val_wrt(wrt),
        .push_msg_val_rd(rdf), .push_msg_data(push_data), .pull_en(pull_en),
        .pull_msg_val(pull_val), .pull_msg_spc(pull_spc), .pull_msg_data(pull_data),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
        .err_ovf(err_ovf), .err_addr(err_addr));

    spi_multi_adapter #(.nbits(16), .num_channels(3), .num_entries(2)) dut3 (
        .clk(clk), .reset(reset), .push_en(t_push_en), .push_msg_val_wrt(t_wrt),
        .push_msg_val_rd(t_rdf), .push_msg_data(t_push_data), .pull_en(t_pull_en),
        .pull_msg_val(t_pull_val), .pull_msg_spc(t_pull_spc), .pull_msg_data(t_pull_data),
        .recv_msg(t_recv_msg), .recv_val(t_recv_val), .recv_rdy(t_recv_rdy),
        .send_msg(t_send_msg), .send_val(t_send_val), .send_rdy(t_send_rdy),
        .err_ovf(t_err_ovf), .err_addr(t_err_addr));

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Scoreboard: expected mc payloads per channel, expected read responses.
    logic [11:0] exp_send [4][$];
    logic [13:0] exp_pull [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push_en = 0; wrt = 0; rdf = 0; pull_en = 0; push_data = '0; recv_val = '0;
        t_push_en = 0; t_wrt = 0; t_rdf = 0; t_pull_en = 0; t_push_data = '0; t_recv_val = '0;
    endtask

    task automatic write(input logic [1:0] c, input logic [11:0] p);
        push_en = 1; wrt = 1; push_data = {c, p};
    endtask

    task automatic read(input logic [1:0] c);
        pull_en = 1; rdf = 1; push_data = {c, 12'h000};
    endtask

    task automatic drain(input int c);
        int budget;
        budget = 0;
        send_rdy[c] = 1'b1;
        while (exp_send[c].size() > 0 && budget < 10) begin
            @(negedge clk);
            if (send_val[c])
                chk("send_msg_order", send_msg[c*PW +: PW], exp_send[c].pop_front());
            cyc();
            budget++;
        end
        send_rdy[c] = 1'b0;
        chk("drain_left", exp_send[c].size(), 0);
        @(negedge clk);
        chk("send_val_after_drain", send_val[c], 0);
        cyc();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        recv_msg = '0; send_rdy = '0; t_recv_msg = '0; t_send_rdy = '0;
        // Outputs held low while in reset, even with an addressable write pending.
        push_en = 1; push_data = {2'd0, 12'h000}; pull_en = 1; rdf = 1;
        #3;
        chk("rst_spc", pull_spc, 0);
        chk("rst_send_val", send_val, 0);
        chk("rst_recv_rdy", recv_rdy, 0);
        chk("rst_pull_val", pull_val, 0);
        chk("rst_pull_data", pull_data, 0);
        #9 reset = 1'b0;
        idle();
        cyc();
        @(negedge clk);
        chk("post_rst_recv_rdy", recv_rdy, 4'hF);
        chk("post_rst_err_ovf", err_ovf, 0);
        chk("post_rst_err_addr", err_addr, 0);
        cyc();

        // Write routing and space indication
        write(2'd2, 12'hABC); exp_send[2].push_back(12'hABC);
        @(negedge clk);
        chk("spc_first_write", pull_spc, 1);
        cyc();
        write(2'd2, 12'hDEF); exp_send[2].push_back(12'hDEF);
        @(negedge clk);
        chk("route_send_val", send_val, 4'b0100);
        chk("route_send_msg", send_msg[2*PW +: PW], exp_send[2][0]);
        chk("spc_second_write", pull_spc, 0);
        cyc();
        idle();
        push_data = {2'd2, 12'h000};
        @(negedge clk);
        chk("spc_full_idle", pull_spc, 0);
        cyc();
        drain(2);

        // Overflow on channel 0
        write(2'd0, 12'h001); exp_send[0].push_back(12'h001);
        cyc();
        write(2'd0, 12'h002); exp_send[0].push_back(12'h002);
        cyc();
        write(2'd0, 12'h003);
        @(negedge clk);
        chk("ovf_spc_full", pull_spc, 0);
        chk("ovf_before", err_ovf, 0);
        cyc();
        idle();
        @(negedge clk);
        chk("ovf_set", err_ovf, 1);
        cyc();
        drain(0);

`ifndef SPI_MULTI_ADAPTER_RR_EN
        // Addressed read
        recv_val = 4'b1000; recv_msg[3*PW +: PW] = 12'h5A5;
        @(negedge clk);
        chk("recv_rdy3", recv_rdy[3], 1);
        cyc();
        idle();
        exp_pull.push_back({2'd3, 12'h5A5});
        read(2'd3);
        @(negedge clk);
        chk("rd3_val", pull_val, 1);
        chk("rd3_data", pull_data, exp_pull.pop_front());
        cyc();
        @(negedge clk);
        chk("rd3_empty_val", pull_val, 0);
        chk("rd3_empty_data", pull_data, 0);
        cyc();
        idle();

        // Read and write to the same channel in one transaction
        recv_val = 4'b0010; recv_msg[1*PW +: PW] = 12'h777;
        cyc();
        idle();
        exp_pull.push_back({2'd1, 12'h777});
        write(2'd1, 12'h123); pull_en = 1; rdf = 1; exp_send[1].push_back(12'h123);
        @(negedge clk);
        chk("rw_val", pull_val, 1);
        chk("rw_data", pull_data, exp_pull.pop_front());
        cyc();
        idle();
        drain(1);
`else
        // Round-robin reads
        recv_val = 4'b1101;
        recv_msg = {12'h333, 12'h222, 12'h000, 12'h111};
        cyc();
        idle();
        exp_pull.push_back({2'd0, 12'h111});
        exp_pull.push_back({2'd2, 12'h222});
        exp_pull.push_back({2'd3, 12'h333});
        for (int i = 0; i < 3; i++) begin
            read(2'd1);
            @(negedge clk);
            chk("rr_val", pull_val, 1);
            chk("rr_data", pull_data, exp_pull.pop_front());
            cyc();
        end
        @(negedge clk);
        chk("rr_empty_val", pull_val, 0);
        chk("rr_empty_data", pull_data, 0);
        cyc();
        idle();
        recv_val = 4'b0101;
        recv_msg = {12'h000, 12'hBBB, 12'h000, 12'hAAA};
        cyc();
        idle();
        exp_pull.push_back({2'd0, 12'hAAA});
        exp_pull.push_back({2'd2, 12'hBBB});
        for (int i = 0; i < 2; i++) begin
            read(2'd3);
            @(negedge clk);
            chk("rr_wrap_val", pull_val, 1);
            chk("rr_wrap_data", pull_data, exp_pull.pop_front());
            cyc();
        end
        idle();
`endif

        // Out-of-range channel on the 3-channel instance
        t_recv_val = 3'b001; t_recv_msg[11:0] = 12'h444;
        cyc();
        idle();
        t_push_en = 1; t_wrt = 1; t_pull_en = 1; t_rdf = 1; t_push_data = {2'd3, 12'h999};
        @(negedge clk);
        chk("bad_spc", t_pull_spc, 0);
        chk("bad_err_before", t_err_addr, 0);
`ifndef SPI_MULTI_ADAPTER_RR_EN
        chk("bad_pull_val", t_pull_val, 0);
        chk("bad_pull_data", t_pull_data, 0);
`else
        chk("bad_rr_pull_val", t_pull_val, 1);
        chk("bad_rr_pull_data", t_pull_data, {2'd0, 12'h444});
`endif
        cyc();
        idle();
        @(negedge clk);
        chk("bad_err_addr", t_err_addr, 1);
        chk("bad_err_ovf", t_err_ovf, 0);
        chk("bad_send_val", t_send_val, 0);
        chk("good_err_addr", err_addr, 0);
        cyc();
        t_pull_en = 1; t_rdf = 1; t_push_data = {2'd0, 12'h000};
        @(negedge clk);
`ifndef SPI_MULTI_ADAPTER_RR_EN
        chk("bad_no_deq_val", t_pull_val, 1);
        chk("bad_no_deq_data", t_pull_data, {2'd0, 12'h444});
`else
        chk("bad_rr_drained", t_pull_val, 0);
`endif
        cyc();
        idle();

        // Reset in the middle of operation
        write(2'd1, 12'hA01);
        cyc();
        write(2'd1, 12'hA02);
        cyc();
        idle();
        @(negedge clk);
        chk("pre_rst_send_val", send_val, 4'b0010);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_send_val", send_val, 0);
        chk("mid_rst_recv_rdy", recv_rdy, 0);
        #3 reset = 1'b0;
        exp_send[1].delete();
        cyc();
        @(negedge clk);
        chk("rel_recv_rdy", recv_rdy, 4'hF);
        chk("rel_send_val", send_val, 0);
        chk("rel_err_ovf", err_ovf, 0);
        chk("rel_err_addr", err_addr, 0);
        chk("rel_t_err_addr", t_err_addr, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/spi_multi_adapter.md
Name: spi_multi_adapter

Overview:
- Multi-channel successor to the single-channel SPI adapter.
- Sits between the SPI minion's push/pull interface and N independent val/rdy stream channels.
- Each SPI packet carries a channel-ID field.
- Per channel: a master-to-chip (mc) queue and a chip-to-master (cm) queue, with parametrised depth.
- Adds sticky error reporting; round-robin read mode is optional.

Parameters:
- nbits, 16: SPI packet width, including the 2 flag bits.
- num_channels, 4: number of stream channels; must be >= 2. CW = $clog2(num_channels).
- num_entries, 2: depth of every per-channel queue; must be >= 1.
- Derived: PW = nbits-2-CW, the payload width; must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- push_en  in  1  push transaction strobe
- push_msg_val_wrt  in  1  write flag
- push_msg_val_rd  in  1  read flag
- push_msg_data  in  nbits-2  {chan[CW-1:0], payload[PW-1:0]}
- pull_en  in  1  pull transaction strobe
- pull_msg_val  out  1  read data valid
- pull_msg_spc  out  1  addressed mc queue can accept another write
- pull_msg_data  out  nbits-2  {chan, payload}
- recv_msg  in  num_channels*PW  chip-to-master payloads; channel i is bits [i*PW +: PW]
- recv_val  in  num_channels  per-channel valid
- recv_rdy  out  num_channels  per-channel ready
- send_msg  out  num_channels*PW  master-to-chip payloads
- send_val  out  num_channels  per-channel valid
- send_rdy  in  num_channels  per-channel ready
- err_ovf  out  1  sticky: a write was dropped
- err_addr  out  1  sticky: a channel ID >= num_channels was used

Behaviour:
- Reset (async, takes effect immediately):
  - All queues empty; rr_ptr=0; err_ovf=0, err_addr=0.
  - recv_rdy, send_val, pull_msg_val, pull_msg_spc, pull_msg_data all 0 while reset is high.
- Queue (each of the 2*num_channels instances):
  - Circular buffer with head/tail pointers wrapping at num_entries, plus a count.
  - rdy = (count < num_entries); val = (count > 0); msg = entry[head].
  - Enqueue and dequeue take effect on the clock edge.
  - Simultaneous enq+deq is allowed when 0 < count < num_entries; count is unchanged.
  - Full queue: enq is blocked. Empty queue: deq is blocked. No bypass; enq->send latency is 1 cycle.
- Write (wr = push_en & push_msg_val_wrt):
  - ch = push_msg_data[nbits-3 -: CW].
  - ch valid and mc[ch] not full: enqueue payload on the edge.
  - mc[ch] full: drop the write, set err_ovf.
  - ch >= num_channels: drop the write, set err_addr.
- Space indication (combinational):
  - pull_msg_spc = mc[ch].rdy & (~wr | mc[ch].free > 1).
  - Forced to 0 when ch is out of range.
- Read (rd = pull_en & push_msg_val_rd):
  - Addressed mode, target = ch.
  - pull_msg_val = rd & cm[target].val, combinational in the same cycle.
  - pull_msg_data = pull_msg_val ? {target, cm[target].msg} : 0.
  - cm[target] dequeues on the edge only when pull_msg_val=1.
  - Read from an empty channel: val=0, data=0, no state change.
  - Out-of-range ch: val=0, and err_addr is set.
- Read and write in the same transaction:
  - Legal and independent, since they use different queue directions, even for the same ch.
- Stream side:
  - recv_val&recv_rdy enqueues into cm[i].
  - send_val&send_rdy dequeues mc[i].
  - All channels operate concurrently with the SPI side.
- Error flags:
  - Sticky; cleared only by reset.

Optional Feature:
- Macro: SPI_MULTI_ADAPTER_RR_EN.
- Defined (round-robin reads):
  - The chan field of the read is ignored.
  - target = first non-empty cm channel, searching from rr_ptr upward with wrap-around.
  - Response carries the target in the chan field.
  - On a successful read, rr_ptr <= target+1 (mod num_channels).
  - All channels empty: val=0, data=0, rr_ptr unchanged.
  - Reads never set err_addr.
- Undefined: addressed reads only; rr_ptr logic is absent.

Test Plan:
- Reset mid-operation:
  - Fill mc[1] with 2 entries, assert reset asynchronously mid-cycle.
  - Required: send_val=0 immediately; after release, all recv_rdy=1 and err_ovf=err_addr=0.
- Write routing:
  - nbits=16, num_channels=4: write {ch=2, payload=0xABC}.
  - Required: next cycle send_val=4'b0100 with send_msg[2]=0xABC.
  - Required: pull_msg_spc=1 during the first write, and 0 during a second write to ch 2 while send_rdy=0.
- Overflow:
  - Three writes to ch 0 with send_rdy=0.
  - Required: first two stored; third dropped; err_ovf=1; send_msg[0] order is 1st then 2nd.
- Addressed read:
  - recv ch 3 payload 0x5A5, then read ch=3.
  - Required: pull_msg_val=1 and data=0x35A5 in the same cycle; a second read gives val=0, data=0.
- Bad address:
  - num_channels=3, write and read to ch=3.
  - Required: nothing enqueued or dequeued; err_addr=1; pull_msg_val=0.
- RR_EN:
  - cm[0]=0x111, cm[2]=0x222, cm[3]=0x333; four reads.
  - Required responses in order: ch0, ch2, ch3, then val=0.
  - Then refill cm[0] and cm[2]: the next read returns ch0, because the pointer wrapped to 0.
